// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// FSM state codes and small op-classification helpers.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Shared iterative datapath: a partial-remainder register (r), a
// quotient/multiplier shift register (q), an operand register (d) and one
// W+1-bit adder. In divide mode each step is one restoring-division bit;
// in multiply mode each step is one shift-add bit with {r,q} as the
// growing 2W-bit product. q_nxt/r_nxt expose the post-step values so the
// owner can commit the final step in the same cycle.
module mdu_div_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         load,
    input  logic         step,
    input  logic         mul,
    input  logic [W-1:0] q_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_o,
    output logic [W-1:0] d_o,
    output logic [W-1:0] q_nxt,
    output logic [W-1:0] r_nxt
);

    logic [W-1:0] q_r;
    logic [W-1:0] r_r;
    logic [W-1:0] d_r;
    logic [W:0]   opx;
    logic [W:0]   opy;
    logic [W+1:0] sum;
    logic [W:0]   mul_t;

    // One shared adder: subtract d from the shifted remainder, or add d to the upper product half
    always_comb begin
        opx   = mul ? {1'b0, r_r} : {r_r, q_r[W-1]};
        opy   = mul ? {1'b0, d_r} : ~{1'b0, d_r};
        sum   = {1'b0, opx} + {1'b0, opy} + {{(W+1){1'b0}}, ~mul};
        mul_t = q_r[0] ? sum[W:0] : {1'b0, r_r};
        if (mul) begin
            r_nxt = mul_t[W:1];
            q_nxt = {mul_t[0], q_r[W-1:1]};
        end else if (sum[W+1]) begin
            // no borrow: the trial subtraction is kept and the quotient bit is 1
            r_nxt = sum[W-1:0];
            q_nxt = {q_r[W-2:0], 1'b1};
        end else begin
            r_nxt = {r_r[W-2:0], q_r[W-1]};
            q_nxt = {q_r[W-2:0], 1'b0};
        end
    end

    // Datapath registers: load operands at start, advance one bit per step
    always_ff @(posedge clk) begin
        if (load) begin
            q_r <= q_in;
            d_r <= d_in;
            r_r <= '0;
        end else if (step) begin
            q_r <= q_nxt;
            r_r <= r_nxt;
        end
    end

    assign q_o = q_r;
    assign d_o = d_r;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers for the execute stage.
// Operands are reduced to magnitudes at start; signs are restored at commit.
// Optional feature macro MDU_ITER_MUL_EN: when defined, multiplies run as W
// shift-add steps on the shared core; otherwise a single-cycle array
// multiply is used and MUL lasts one cycle.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] HILO_RST = '0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         stall,
    output logic         done,
    output logic         busy,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam int CNT_W = $clog2(W) + 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             b_zero;
    logic             go;
    logic             cnt_last;
    logic             mul_last;
    logic             core_mul;
    logic [W-1:0]     q_in;
    logic [W-1:0]     d_in;
    logic [W-1:0]     q_o;
    logic [W-1:0]     d_o;
    logic [W-1:0]     q_nxt;
    logic [W-1:0]     r_nxt;
    logic [W-1:0]     quot_fix;
    logic [W-1:0]     rem_fix;
    logic [2*W-1:0]   prod_mag;
    logic [2*W-1:0]   prod;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
        return (sgn && x[W-1]) ? -x : x;
    endfunction

    assign go       = (state == ST_IDLE) && start && !flush && op_is_muldiv(op);
    assign cnt_last = (cnt == CNT_W'(W - 1));
    assign done     = (state == ST_DONE);
    assign busy     = (state != ST_IDLE);
    assign stall    = start && op_is_muldiv(op) && !done && !flush;

    // Multiplicand goes to d and multiplier to q; for divides q holds the dividend
    assign q_in = op_is_mul(op) ? mag(b, op_is_signed(op)) : mag(a, op_is_signed(op));
    assign d_in = op_is_mul(op) ? mag(a, op_is_signed(op)) : mag(b, op_is_signed(op));

`ifdef MDU_ITER_MUL_EN
    assign core_mul = (state == ST_MUL);
    assign mul_last = cnt_last;
    assign prod_mag = {r_nxt, q_nxt};
`else
    assign core_mul = 1'b0;
    assign mul_last = 1'b1;
    assign prod_mag = {{W{1'b0}}, d_o} * {{W{1'b0}}, q_o};
`endif

    mdu_div_core #(.W(W)) u_core (
        .clk   (clk),
        .load  (go),
        .step  ((state == ST_DIV) || (state == ST_MUL)),
        .mul   (core_mul),
        .q_in  (q_in),
        .d_in  (d_in),
        .q_o   (q_o),
        .d_o   (d_o),
        .q_nxt (q_nxt),
        .r_nxt (r_nxt)
    );

    // Sign fix-up at commit; negation wraps mod 2^W, which also covers MIN / -1
    always_comb begin
        prod     = neg_q ? -prod_mag : prod_mag;
        quot_fix = b_zero ? {W{1'b1}} : (neg_q ? -q_nxt : q_nxt);
        rem_fix  = neg_r ? -r_nxt : r_nxt;
    end

    // Sign flags captured alongside the operand magnitudes
    always_ff @(posedge clk) begin
        if (go) begin
            neg_q  <= op_is_signed(op) && (a[W-1] ^ b[W-1]);
            neg_r  <= op_is_signed(op) && a[W-1];
            b_zero <= (b == '0);
        end
    end

    // Control FSM; flush returns to IDLE from any state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= op_is_mul(op) ? ST_MUL : ST_DIV;
                        cnt   <= '0;
                    end
                end
                ST_MUL: begin
                    if (mul_last) state <= ST_DONE;
                    cnt <= cnt + CNT_W'(1);
                end
                ST_DIV: begin
                    if (cnt_last) state <= ST_DONE;
                    cnt <= cnt + CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // HI/LO: direct moves in IDLE, result write on the final iteration
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_o <= HILO_RST;
            lo_o <= HILO_RST;
        end else if (!flush) begin
            if (state == ST_IDLE && start && op == MDU_MTHI) begin
                hi_o <= a;
            end else if (state == ST_IDLE && start && op == MDU_MTLO) begin
                lo_o <= a;
            end else if (state == ST_MUL && mul_last) begin
                hi_o <= prod[2*W-1:W];
                lo_o <= prod[W-1:0];
            end else if (state == ST_DIV && cnt_last) begin
                hi_o <= rem_fix;
                lo_o <= quot_fix;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (W=32) with a plain-arithmetic reference.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         start  = 1'b0;
    logic         flush  = 1'b0;
    logic [2:0]   op     = 3'd7;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         stall;
    logic         done;
    logic         busy;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_iter #(.W(W), .HILO_RST('0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .busy   (busy),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {HI,LO} from ordinary integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [31:0]     q;
        logic [31:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        q  = '0;
        r  = '0;
        case (o)
            MDU_MULT:  return 64'(sx * sy);
            MDU_MULTU: return 64'(ux * uy);
            MDU_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = 32'(sx / sy);
                r = 32'(sx % sy);
                return {r, q};
            end
            MDU_DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = 32'(ux / uy);
                r = 32'(ux % uy);
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int exp_stall(input logic [2:0] o);
        if (o == MDU_DIV || o == MDU_DIVU) return W + 1;
`ifdef MDU_ITER_MUL_EN
        return W + 1;
`else
        return 2;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          stalls;
        int          cyc;
        logic [63:0] exp_r;
        exp_r  = model(o, x, y);
        stalls = 0;
        cyc    = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        while (done !== 1'b1 && cyc < 100) begin
            if (stall === 1'b1) stalls++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_stall_in_done"}, 64'(stall), 64'd0);
        start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
        check({tag, "_stall_len"}, 64'(stalls), 64'(exp_stall(o)));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'({busy, done}), 64'd0);
        check({tag, "_hilo"}, {hi_o, lo_o}, exp_r);
    endtask

    logic [31:0] hi_prev;
    logic [31:0] lo_prev;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_flags", 64'({stall, done, busy}), 64'd0);
        resetn = 1'b1;

        // directed cases
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_by0", MDU_DIVU, 32'd5, 32'd0);
        run_op("div_neg_by0", MDU_DIV, 32'hFFFF_FFFB, 32'd0);
        run_op("mult_m3_5", MDU_MULT, 32'hFFFF_FFFD, 32'd5);
        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE);

        // flush during DIV iteration 10
        hi_prev = hi_o;
        lo_prev = lo_o;
        @(negedge clk);
        start = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0; op = 3'd7;
        check("flush_idle", 64'({busy, done}), 64'd0);
        check("flush_hilo", {hi_o, lo_o}, {hi_prev, lo_prev});
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_done", 64'(done), 64'd0);

        // MTHI then MTLO back-to-back
        @(negedge clk);
        start = 1'b1; op = MDU_MTHI; a = 32'h1234;
        #1;
        check("mthi_stall", 64'(stall), 64'd0);
        @(negedge clk);
        op = MDU_MTLO; a = 32'h5678;
        #1;
        check("mtlo_stall", 64'(stall), 64'd0);
        check("mthi_hi", 64'(hi_o), 64'h1234);
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        #1;
        check("mt_hilo", {hi_o, lo_o}, {32'h1234, 32'h5678});
        check("mt_busy", 64'(busy), 64'd0);

        // flush dominates an MT write in the same cycle
        @(negedge clk);
        start = 1'b1; op = MDU_MTHI; a = 32'hDEAD; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd7; flush = 1'b0;
        check("mt_flush_hi", 64'(hi_o), 64'h1234);

        // randomized operations, with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'd0;
                default: ;
            endcase
            run_op("rand", rop, ra, rb);
        end

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        check("rstmid_busy", 64'(busy), 64'd1);
        resetn = 1'b0; start = 1'b0; op = 3'd7;
        #1;
        check("rstmid_hilo", {hi_o, lo_o}, 64'd0);
        check("rstmid_busy0", 64'(busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rstmid_after", {hi_o, lo_o}, 64'd0);
        check("rstmid_done", 64'({busy, done}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
